// File: rtl/imem_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, fetches from combinational instruction memory
// into a 2-entry buffer and hands entries to decode; execute redirects flush and restart.
module imem_fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_enable,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [63:0] dec_pc,
  output logic [15:0] redirect_count
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned RC_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [XLEN-1:0]     pc;
  logic [ILEN-1:0]     buf_inst [2];
  logic [XLEN-1:0]     buf_pc   [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                fetch_fire;
  logic                pop;
  logic                not_empty;

  assign not_empty    = (count != CNT_W'(0));
  assign fetch_fire   = (state == RUN) && (count < CNT_W'(2)) && !redirect_valid;
  // Redirect gates the handshake so no stale entry is accepted in the flush cycle.
  assign dec_valid    = not_empty && !redirect_valid;
  assign pop          = dec_valid && dec_ready;
  assign dec_inst     = not_empty ? buf_inst[rd_ptr] : ILEN'(0);
  assign dec_pc       = not_empty ? buf_pc[rd_ptr]   : XLEN'(0);
  assign Inst_Address = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (state == IDLE) ? IDLE : FLUSH;
    end else begin
      case (state)
        IDLE, RUN, FLUSH: state_nxt = fetch_enable ? RUN : IDLE;
        default:          state_nxt = IDLE;
      endcase
    end
  end

  // PC, buffer pointers/occupancy and the saturating redirect counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= CNT_W'(0);
      redirect_count <= RC_W'(0);
    end else if (redirect_valid) begin
      pc      <= redirect_pc;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= CNT_W'(0);
      if (redirect_count != {RC_W{1'b1}}) redirect_count <= redirect_count + RC_W'(1);
    end else begin
      if (fetch_fire) begin
        pc     <= pc + XLEN'(4);
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + CNT_W'(fetch_fire) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset: an empty buffer presents zeros.
  always_ff @(posedge clk) begin
    if (fetch_fire) begin
      buf_inst[wr_ptr] <= Instruction;
      buf_pc[wr_ptr]   <= pc;
    end
  end

endmodule

// File: doc/imem_fetch_sequencer.md
# imem_fetch_sequencer

Fetch-stage controller for the pipelined RISC-V core. It owns the program counter and drives the word address into the combinational instruction memory. It captures each returned instruction with its PC into a 2-entry fetch buffer and hands entries to decode over a valid/ready handshake. Branch redirects from execute flush the buffer and restart fetch at the target.

## Interface
- RESET_PC, 64'h0, PC loaded at reset and the first fetch address.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_enable  in  1  level; 1 = sequencer may fetch.
- Inst_Address  out  64  byte address to instruction memory; always equals the PC register.
- Instruction  in  32  instruction word from memory; combinational, valid in the same cycle as Inst_Address.
- redirect_valid  in  1  one-cycle pulse from execute: a resolved branch/jump or a mispredict.
- redirect_pc  in  64  target PC, sampled when redirect_valid=1.
- dec_valid  out  1  head buffer entry available to decode.
- dec_ready  in  1  decode accepts the head entry this cycle.
- dec_inst  out  32  head entry instruction; 0 when the buffer is empty.
- dec_pc  out  64  head entry PC; 0 when the buffer is empty.
- redirect_count  out  16  number of redirects taken; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, RUN, FLUSH. Reset state is IDLE.
  - IDLE: no fetch. Moves to RUN at the next edge when fetch_enable=1.
  - RUN: fetches. Moves to IDLE at the next edge when fetch_enable=0.
  - FLUSH: one-cycle redirect bubble with no fetch. Always moves next to RUN if fetch_enable=1, else to IDLE.
- redirect_valid=1 in any state, evaluated first:
  - PC <= redirect_pc;
  - buffer count <= 0;
  - next state FLUSH, or IDLE if the current state is IDLE;
  - redirect_count += 1 (saturating);
  - no fetch occurs in that cycle.
- fetch_fire = (state==RUN) && (count<2) && !redirect_valid.
  - On fetch_fire, {PC, Instruction} is written at the tail and PC <= PC + 4.
  - PC arithmetic is 64-bit modulo 2^64; the sequencer never masks the address (memory decodes the low bits).
- pop = dec_valid && dec_ready.
  - dec_valid = (count!=0) && !redirect_valid. Redirect gates off the handshake, so no stale instruction is accepted in the flush cycle.
- Buffer: 2-entry circular FIFO with 1-bit read/write pointers and a 2-bit count.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full (count==2): no fetch, even if pop occurs that cycle. A pop only frees a slot for the next cycle.
  - Empty: dec_inst=0, dec_pc=0.
- fetch_enable dropping to 0 stops new fetches only. Buffered entries still drain to decode.

## Timing
- Reset (reset_n=0, asynchronous) forces:
  - state=IDLE, PC=RESET_PC, Inst_Address=RESET_PC;
  - count=0, pointers=0, dec_valid=0, dec_inst=0, dec_pc=0, redirect_count=0.
- Reset asserted mid-operation discards the buffer and PC immediately, with no drain.
- Start-up latency: fetch_enable sampled high at edge E1 (IDLE->RUN); first fetch written at E2; dec_valid=1 after E2.
- Steady-state throughput is 1 instruction/cycle with dec_ready held at 1. Count holds at 1.
- Redirect penalty: redirect at edge R; FLUSH during cycle R..R+1; fetch of redirect_pc written at R+2; dec_valid after R+2. This gives 2 bubble cycles.
- Backpressure: with dec_ready=0, the buffer fills to 2 within 2 fetch cycles. Inst_Address then holds at the next unfetched PC.

## Test plan
Bench memory model: Instruction = 32'hA000_0000 | Inst_Address[31:0].

- Reset then fetch_enable=1, dec_ready=1 for 4 cycles:
  - dec_pc sequence 0, 4, 8, 12;
  - dec_inst sequence A0000000, A0000004, A0000008, A000000C;
  - no gaps after the first dec_valid.
- dec_ready=0 for 5 cycles after start:
  - count reaches 2; Inst_Address holds at 8; dec_pc stays 0.
  - After release, entries 0, 4, 8 are delivered in order with no loss or duplication.
- Redirect with redirect_pc=0x40 while 2 entries are buffered:
  - dec_valid=0 in the redirect cycle and the FLUSH cycle;
  - next delivered dec_pc=0x40, then 0x44;
  - redirect_count=1.
- Redirect in IDLE (fetch_enable=0), redirect_pc=0x100, then enable:
  - Inst_Address=0x100 after the edge; first dec_pc=0x100.
- fetch_enable dropped with 2 entries buffered:
  - both entries still delivered; no further fetch; Inst_Address frozen.
- reset_n pulsed low mid-stream, asynchronously between edges:
  - outputs clear immediately; Inst_Address=RESET_PC;
  - with fetch_enable held at 1, fetch resumes from 0 after release.
